// File: rtl/bit_img_pkg.sv
// Shared types and constants for binary-image detector blocks.
//   COORD_W        : pixel coordinate width (x and y)
//   CNT_W          : set-pixel counter width
//   COORD_SENTINEL : start value for working minima, so the first hit always wins
//   bbox_t         : min/max bounding box
//   on_border()    : true when (x,y) lies on the outline of a box
package bit_img_pkg;

    localparam int COORD_W = 11;
    localparam int CNT_W   = 22;

    localparam logic [COORD_W-1:0] COORD_SENTINEL = 11'd2047;
    localparam logic [CNT_W-1:0]   CNT_MAX        = 22'h3FFFFF;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } bbox_t;

    localparam bbox_t BBOX_INIT = '{xmin: COORD_SENTINEL, xmax: '0,
                                    ymin: COORD_SENTINEL, ymax: '0};
    localparam bbox_t BBOX_ZERO = '0;

    function automatic logic on_border(input bbox_t b,
                                       input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        logic in_x, in_y;
        in_x = (x >= b.xmin) && (x <= b.xmax);
        in_y = (y >= b.ymin) && (y <= b.ymax);
        return (((y == b.ymin) || (y == b.ymax)) && in_x) ||
               (((x == b.xmin) || (x == b.xmax)) && in_y);
    endfunction

endpackage

// File: rtl/bit_pixel_coord_counter.sv
// Pixel coordinate tracker for a vsync/href video stream.
//   clk, rst_n   : pixel clock, async active-low reset
//   vsync, href  : input frame / line valid
//   x, y         : coordinates of the pixel currently on the inputs (0-based)
//   vsync_dly    : vsync delayed one cycle
//   href_dly     : href delayed one cycle
//   frame_start  : vsync rising edge, qualified (see below)
//   frame_end    : vsync falling edge (raw)
module bit_pixel_coord_counter
    import bit_img_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               href,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               vsync_dly,
    output logic               href_dly,
    output logic               frame_start,
    output logic               frame_end
);

    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic               seen_low_q, seen_low_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               href_fall;

    always_comb begin
        vsync_d    = vsync;
        href_d     = href;
        // After reset vsync_q reads 0 even if the frame is already running;
        // a rise only counts once vsync has actually been seen low.
        seen_low_d = seen_low_q | ~vsync;
        href_fall  = href_q & ~href;

        // Counters saturate so an over-long line/frame can never wrap back
        // into the active window.
        x_d = x_q;
        if (!href)
            x_d = '0;
        else if (x_q != '1)
            x_d = x_q + 1'b1;

        y_d = y_q;
        if (!vsync)
            y_d = '0;
        else if (href_fall && (y_q != '1))
            y_d = y_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            seen_low_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            vsync_q    <= vsync_d;
            href_q     <= href_d;
            seen_low_q <= seen_low_d;
            x_q        <= x_d;
            y_q        <= y_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign vsync_dly   = vsync_q;
    assign href_dly    = href_q;
    assign frame_start = vsync & ~vsync_q & seen_low_q;
    assign frame_end   = ~vsync & vsync_q;

endmodule

// File: rtl/bit_bbox_detector.sv
// Bounding-box detector for a binary image stream, with box overlay.
//   clk, rst_n                    : pixel clock, async active-low reset
//   per_frame_vsync/href/img_Bit  : input video (Bit 1 = target)
//   post_frame_vsync/href         : input timing delayed one cycle
//   post_img_Bit                  : delayed pixel OR outline of last frame's box
//   box_xmin/xmax/ymin/ymax       : bounding box of last completed frame
//   pixel_count                   : set pixels in last completed frame
//   box_valid                     : pixel_count >= MIN_PIXELS
//   frame_done                    : one-cycle pulse when results update
module bit_bbox_detector
    import bit_img_pkg::*;
#(
    parameter logic [COORD_W-1:0] IMG_HDISP  = 11'd640,
    parameter logic [COORD_W-1:0] IMG_VDISP  = 11'd480,
    parameter logic [CNT_W-1:0]   MIN_PIXELS = 22'd16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               per_frame_vsync,
    input  logic               per_frame_href,
    input  logic               per_img_Bit,
    output logic               post_frame_vsync,
    output logic               post_frame_href,
    output logic               post_img_Bit,
    output logic [COORD_W-1:0] box_xmin,
    output logic [COORD_W-1:0] box_xmax,
    output logic [COORD_W-1:0] box_ymin,
    output logic [COORD_W-1:0] box_ymax,
    output logic [CNT_W-1:0]   pixel_count,
    output logic               box_valid,
    output logic               frame_done
);

    logic [COORD_W-1:0] x, y;
    logic               vsync_dly, href_dly, frame_start, frame_end;

    bit_pixel_coord_counter u_coord (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (per_frame_vsync),
        .href        (per_frame_href),
        .x           (x),
        .y           (y),
        .vsync_dly   (vsync_dly),
        .href_dly    (href_dly),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    bbox_t            work_q, work_d, box_q, box_d, base;
    logic [CNT_W-1:0] work_cnt_q, work_cnt_d, base_cnt;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             active_q, active_d;
    logic             bit_q, bit_d;
    logic             border_q, border_d;
    logic             pix_hit, latch;

    always_comb begin
        // A frame is only tracked from a qualified rise; anything in flight
        // when reset released is ignored until the next full frame.
        pix_hit = per_frame_vsync & per_frame_href & per_img_Bit &
                  (x < IMG_HDISP) & (y < IMG_VDISP) & (active_q | frame_start);

        // On the rise cycle, start from fresh values so a pixel in that very
        // cycle still lands in the new frame.
        base     = frame_start ? BBOX_INIT : work_q;
        base_cnt = frame_start ? '0 : work_cnt_q;

        work_d     = base;
        work_cnt_d = base_cnt;
        if (pix_hit) begin
            if (x < base.xmin) work_d.xmin = x;
            if (x > base.xmax) work_d.xmax = x;
            if (y < base.ymin) work_d.ymin = y;
            if (y > base.ymax) work_d.ymax = y;
            if (base_cnt != CNT_MAX) work_cnt_d = base_cnt + 1'b1;
        end

        active_d = active_q;
        if (frame_start)
            active_d = 1'b1;
        else if (frame_end)
            active_d = 1'b0;

        latch   = frame_end & active_q;
        box_d   = box_q;
        count_d = count_q;
        valid_d = valid_q;
        if (latch) begin
            box_d   = (work_cnt_q == '0) ? BBOX_ZERO : work_q;
            count_d = work_cnt_q;
            valid_d = (work_cnt_q >= MIN_PIXELS);
        end
        done_d = latch;

        // Latching only happens in vertical blank, so box_q is stable for the
        // whole active frame and the overlay always shows the previous frame.
        bit_d    = per_img_Bit;
        border_d = per_frame_vsync & per_frame_href & valid_q & on_border(box_q, x, y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q     <= BBOX_ZERO;
            work_cnt_q <= '0;
            box_q      <= BBOX_ZERO;
            count_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            active_q   <= 1'b0;
            bit_q      <= 1'b0;
            border_q   <= 1'b0;
        end else begin
            work_q     <= work_d;
            work_cnt_q <= work_cnt_d;
            box_q      <= box_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            active_q   <= active_d;
            bit_q      <= bit_d;
            border_q   <= border_d;
        end
    end

    assign post_frame_vsync = vsync_dly;
    assign post_frame_href  = href_dly;
    assign post_img_Bit     = href_dly & (bit_q | border_q);
    assign box_xmin         = box_q.xmin;
    assign box_xmax         = box_q.xmax;
    assign box_ymin         = box_q.ymin;
    assign box_ymax         = box_q.ymax;
    assign pixel_count      = count_q;
    assign box_valid        = valid_q;
    assign frame_done       = done_q;

endmodule
